mult_div_seq: RTL
=================

Name: mult_div_seq

Overview:
Iterative signed multiply/divide unit. It is the responder to the control unit's 2-bit mult/div command. It takes operands from the A/B registers and produces the HI/LO register inputs plus the div-by-zero exception flag. It replaces the combinational-latency assumption with an explicit busy/done handshake, so the control FSM waits on done instead of counting cycles.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
a_in  input  WIDTH  operand A; multiplicand or dividend.
b_in  input  WIDTH  operand B; multiplier or divisor.
div_mult_ctrl  input  2  command: 00 idle, 01 MULT, 10 DIV, 11 reserved (treated as idle).
hi_out  output  WIDTH  MULT: product[2*WIDTH-1:WIDTH]; DIV: remainder.
lo_out  output  WIDTH  MULT: product[WIDTH-1:0]; DIV: quotient.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; hi_out/lo_out are valid from this cycle on.
div_zero  output  1  one-cycle pulse on DIV with b_in == 0.

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, armed=1.
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
  - The counter and internal registers are cleared.
  - Reset in any state aborts the operation; no done pulse.
- States: IDLE, MULT_RUN, DIV_RUN, FINISH.
- Re-arm rule: armed clears when a command is accepted. It sets again on any cycle where div_mult_ctrl==00. A command is accepted only in IDLE with armed=1, so a command held high never retriggers.
- IDLE, command accepted:
  - a_in and b_in are latched on this edge and ignored afterwards.
  - busy=1 from the next cycle. Counter=0.
  - MULT goes to MULT_RUN.
  - DIV with b_in!=0 goes to DIV_RUN.
  - DIV with b_in==0 stays in IDLE. div_zero=1 for exactly one cycle. hi_out/lo_out are unchanged, busy stays 0, and done does not pulse.
- MULT_RUN: radix-2 Booth.
  - Accumulator is {P_hi[WIDTH-1:0], P_lo = multiplier, q_-1 = 0}.
  - Each cycle, on bit pair {P_lo[0], q_-1}: 01 adds the multiplicand to P_hi, 10 subtracts it, 00/11 do nothing.
  - Then an arithmetic right shift of the whole {P_hi, P_lo, q_-1}.
  - WIDTH iterations, then go to FINISH.
- DIV_RUN: restoring division on magnitudes.
  - |a| and |b| are computed at accept.
  - WIDTH iterations: shift remainder/quotient left, trial-subtract the divisor, keep the result if non-negative, set the quotient bit.
  - Then go to FINISH.
  - Sign fix-up is applied in FINISH:
    - Quotient is negated if the signs differ, i.e. truncation toward zero.
    - Remainder takes the sign of the dividend.
    - -2^(WIDTH-1) / -1 yields quotient 0x80000000 and remainder 0; no flag.
- FINISH:
  - hi_out/lo_out are registered.
  - done=1 for one cycle, busy=0 from the same cycle.
  - Next state is IDLE.
- Latency: if a command is sampled at edge N, done is high in the cycle after edge N+WIDTH+1 (33 cycles after accept for WIDTH=32). Latency is fixed and independent of operand values.
- busy=1 exactly in MULT_RUN and DIV_RUN.
- Commands arriving while busy or in FINISH are ignored, but a 00 during these states still re-arms.
- hi_out/lo_out hold their last result in IDLE. They change only in FINISH or on reset.
- All arithmetic is WIDTH+1 bits internally; no overflow flag is produced.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001; then a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi/lo=0x11/0x22 -> div_zero high exactly one cycle after accept; busy and done never assert; hi/lo stay 0x11/0x22.
- Hold div_mult_ctrl=01 for 80 cycles -> exactly one done pulse; drop ctrl to 00 for one cycle, then 10 -> new DIV accepted.
- Assert reset 10 cycles into a MULT -> next cycle busy=0, done=0, hi=lo=0, state IDLE; a fresh MULT 3*4 then gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_seq_if.sv
//------------------------------------------------------------------------------
// Module  : mult_div_seq_if
// Brief   : Command/result bundle between the control unit and mult_div_seq.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       div_mult_ctrl;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output a_in, b_in, div_mult_ctrl,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  a_in, b_in, div_mult_ctrl,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_seq.sv
//------------------------------------------------------------------------------
// Module  : mult_div_seq
// Brief   : Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_div_seq_if.slave        bus
);

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_MULT_RUN = 2'd1;
  localparam logic [1:0]       c_DIV_RUN  = 2'd2;
  localparam logic [1:0]       c_FINISH   = 2'd3;
  localparam logic [1:0]       c_CMD_IDLE = 2'b00;
  localparam logic [1:0]       c_CMD_MULT = 2'b01;
  localparam logic [1:0]       c_CMD_DIV  = 2'b10;
  localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   ph_q;      // Booth P_hi (sign-extended) / division remainder
  logic [WIDTH-1:0] pl_q;      // Booth P_lo (multiplier) / dividend-quotient
  logic             qm1_q;
  logic [WIDTH-1:0] opnd_q;    // multiplicand / |divisor|
  logic             op_div_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             div_zero_q;

  logic             w_cmd_mult;
  logic             w_cmd_div;
  logic             w_accept;
  logic             w_busy;
  logic             w_last;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_mcand_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    if (bus.div_mult_ctrl == c_CMD_IDLE) begin
      armed_d = 1'b1;
    end else if (w_accept) begin
      armed_d = 1'b0;
    end
    case (state_q)
      c_IDLE: begin
        if (w_accept && w_cmd_mult) begin
          state_d = c_MULT_RUN;
        end else if (w_accept && w_cmd_div && !w_b_zero) begin
          state_d = c_DIV_RUN;
        end
      end
      c_MULT_RUN,
      c_DIV_RUN: begin
        if (w_last) begin
          state_d = c_FINISH;
        end
      end
      c_FINISH: state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_cmd_mult = (bus.div_mult_ctrl == c_CMD_MULT);
    w_cmd_div  = (bus.div_mult_ctrl == c_CMD_DIV);
    w_accept   = (state_q == c_IDLE) && armed_q && (w_cmd_mult || w_cmd_div);
    w_busy     = (state_q == c_MULT_RUN) || (state_q == c_DIV_RUN);
    w_last     = w_busy && (cnt_q == c_LAST);
  end

  always_comb begin
    w_b_zero    = (bus.b_in == '0);
    w_abs_a     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    w_abs_b     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
    w_mcand_ext = {opnd_q[WIDTH-1], opnd_q};
    case ({pl_q[0], qm1_q})
      2'b01:   w_booth_sum = ph_q + w_mcand_ext;
      2'b10:   w_booth_sum = ph_q - w_mcand_ext;
      default: w_booth_sum = ph_q;
    endcase
    w_div_shift = {ph_q[WIDTH-1:0], pl_q[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, opnd_q};
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    w_quo = (sign_a_q ^ sign_b_q) ? -pl_q : pl_q;
    w_rem = sign_a_q ? -ph_q[WIDTH-1:0] : ph_q[WIDTH-1:0];
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      ph_q       <= '0;
      pl_q       <= '0;
      qm1_q      <= 1'b0;
      opnd_q     <= '0;
      op_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (w_accept) begin
        cnt_q    <= '0;
        qm1_q    <= 1'b0;
        ph_q     <= '0;
        sign_a_q <= bus.a_in[WIDTH-1];
        sign_b_q <= bus.b_in[WIDTH-1];
        op_div_q <= w_cmd_div;
        if (w_cmd_mult) begin
          pl_q   <= bus.b_in;
          opnd_q <= bus.a_in;
        end else begin
          pl_q       <= w_abs_a;
          opnd_q     <= w_abs_b;
          div_zero_q <= w_b_zero;
        end
      end else if (state_q == c_MULT_RUN) begin
        ph_q  <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        pl_q  <= {w_booth_sum[0], pl_q[WIDTH-1:1]};
        qm1_q <= pl_q[0];
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == c_DIV_RUN) begin
        ph_q  <= w_div_trial[WIDTH] ? w_div_shift : w_div_trial;
        pl_q  <= {pl_q[WIDTH-2:0], ~w_div_trial[WIDTH]};
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == c_FINISH) begin
        hi_q   <= op_div_q ? w_rem : ph_q[WIDTH-1:0];
        lo_q   <= op_div_q ? w_quo : pl_q;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign bus.busy     = w_busy;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

`default_nettype wire
